input_mems: RTL

- Input-side buffer of the 2D convolution accelerator; the counterpart of the output FIFO.
- Accepts an AXI-Stream of weight matrix W (K×K) and input matrix X (R×C) and stores both in internal dual-port memories.
- Once a full frame is stored, asserts inputs_loaded and serves random-access reads to the compute datapath until compute_finished is received.

---
 rtl/input_mems.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/input_mems.sv
// Input-side frame buffer for the 2D convolution accelerator: loads W (KxK) and X (RxC)
// from an AXI-Stream into two dual-port memories and serves 1-cycle random reads until released.

module memory_dual_port #(
    parameter int DW    = 12,
    parameter int DEPTH = 81,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Same-address write-during-read forwards the incoming word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_rdata <= '0;
        else if (i_we && (i_waddr == i_raddr))
            o_rdata <= i_wdata;
        else
            o_rdata <= r_mem[i_raddr];
    end
endmodule

module input_mems #(
    parameter  int INW    = 12,
    parameter  int R      = 9,
    parameter  int C      = 8,
    parameter  int MAXK   = 9,
    localparam int XADDRW = $clog2(R*C),
    localparam int WADDRW = $clog2(MAXK*MAXK),
    localparam int KW     = $clog2(MAXK+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INW-1:0]    AXIS_TDATA,
    input  logic              AXIS_TVALID,
    input  logic [KW:0]       AXIS_TUSER,
    output logic              AXIS_TREADY,
    output logic              inputs_loaded,
    input  logic              compute_finished,
    output logic [KW-1:0]     K,
    input  logic [XADDRW-1:0] X_read_addr,
    output logic [INW-1:0]    X_data,
    input  logic [WADDRW-1:0] W_read_addr,
    output logic [INW-1:0]    W_data
);
    localparam int NMAX = (MAXK*MAXK > R*C) ? MAXK*MAXK : R*C;
    localparam int CNTW = $clog2(NMAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [CNTW-1:0] r_cnt, w_cnt_next;
    logic [KW-1:0]   r_k, w_k_next;
    logic            w_xfer, w_we_w, w_we_x, w_last_w, w_last_x;
    logic [2*KW-1:0] w_kk;

    assign AXIS_TREADY   = reset && (r_state != S_DONE);
    assign inputs_loaded = (r_state == S_DONE);
    assign K             = r_k;

    assign w_xfer   = AXIS_TVALID && AXIS_TREADY;
    assign w_kk     = {{KW{1'b0}}, r_k} * {{KW{1'b0}}, r_k};
    assign w_last_w = (32'(r_cnt) == (32'(w_kk) - 32'd1));
    assign w_last_x = (32'(r_cnt) == R*C-1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_k     <= w_k_next;
        end
    end

    // In IDLE the counter is always zero, so r_cnt doubles as the write address in every state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_k_next     = r_k;
        w_we_w       = 1'b0;
        w_we_x       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (AXIS_TUSER[0]) begin
                        w_k_next = AXIS_TUSER[KW:1];
                        w_we_w   = 1'b1;
                        if (AXIS_TUSER[KW:1] == KW'(1)) begin
                            w_state_next = S_LOAD_X;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = S_LOAD_W;
                            w_cnt_next   = CNTW'(1);
                        end
                    end else begin
                        w_we_x = 1'b1;
                        if (R*C == 1) begin
                            w_state_next = S_DONE;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = S_LOAD_X;
                            w_cnt_next   = CNTW'(1);
                        end
                    end
                end
            end
            S_LOAD_W: begin
                if (w_xfer) begin
                    w_we_w = 1'b1;
                    if (w_last_w) begin
                        w_state_next = S_LOAD_X;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNTW'(1);
                    end
                end
            end
            S_LOAD_X: begin
                if (w_xfer) begin
                    w_we_x = 1'b1;
                    if (w_last_x) begin
                        w_state_next = S_DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNTW'(1);
                    end
                end
            end
            S_DONE: begin
                if (compute_finished) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    memory_dual_port #(.DW(INW), .DEPTH(MAXK*MAXK), .AW(WADDRW)) u_w_mem (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we_w),
        .i_waddr (r_cnt[WADDRW-1:0]),
        .i_wdata (AXIS_TDATA),
        .i_raddr (W_read_addr),
        .o_rdata (W_data)
    );

    memory_dual_port #(.DW(INW), .DEPTH(R*C), .AW(XADDRW)) u_x_mem (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we_x),
        .i_waddr (r_cnt[XADDRW-1:0]),
        .i_wdata (AXIS_TDATA),
        .i_raddr (X_read_addr),
        .o_rdata (X_data)
    );
endmodule
